// File: rtl/fir_pkg.sv
// Shared definitions for the FIR blocks: FSM encoding, width helpers and the
// saturation classifier used when reducing a wide accumulator to output width.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } fir_state_t;

  typedef enum logic [1:0] {
    SAT_NONE = 2'd0,
    SAT_HI   = 2'd1,
    SAT_LO   = 2'd2
  } fir_sat_t;

  function automatic int fir_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Index ports need at least one bit even for a single-tap filter.
  function automatic int fir_addr_bits(input int num_taps);
    return (fir_clog2(num_taps) < 1) ? 1 : fir_clog2(num_taps);
  endfunction

  function automatic int fir_acc_bits(input int bits_per_elem, input int coef_bits,
                                      input int num_taps);
    return bits_per_elem + coef_bits + fir_clog2(num_taps);
  endfunction

  // Reports whether a value lies above, below or inside the signed out_bits range.
  function automatic fir_sat_t fir_sat_reduce(input logic signed [63:0] v, input int out_bits);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (out_bits - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (out_bits - 1));
    if (v > hi) return SAT_HI;
    if (v < lo) return SAT_LO;
    return SAT_NONE;
  endfunction

endpackage

// File: rtl/fir_mac_serial_if.sv
// Tap bus, start strobe, coefficient write port and result signals of one
// serial FIR MAC instance.
interface fir_mac_serial_if import fir_pkg::*; #(
  parameter int BITS_PER_ELEM = 8,
  parameter int NUM_TAPS      = 9,
  parameter int COEF_BITS     = 8,
  parameter int OUT_BITS      = 8
);
  localparam int ADDR_BITS = fir_addr_bits(NUM_TAPS);

  logic [NUM_TAPS*BITS_PER_ELEM-1:0] i_taps;
  logic                              i_start_calc;
  logic                              i_coef_we;
  logic [ADDR_BITS-1:0]              i_coef_addr;
  logic signed [COEF_BITS-1:0]       i_coef_data;
  logic signed [OUT_BITS-1:0]        o_value;
  logic                              o_valid;
  logic                              o_busy;
  logic                              o_overrun;

  modport master (
    output i_taps, i_start_calc, i_coef_we, i_coef_addr, i_coef_data,
    input  o_value, o_valid, o_busy, o_overrun
  );

  modport slave (
    input  i_taps, i_start_calc, i_coef_we, i_coef_addr, i_coef_data,
    output o_value, o_valid, o_busy, o_overrun
  );

endinterface

// File: rtl/fir_coef_bank.sv
// Coefficient register file: gated write with out-of-range addresses dropped,
// combinational read by tap index.
module fir_coef_bank #(
  parameter int NUM_TAPS  = 9,
  parameter int COEF_BITS = 8,
  parameter int ADDR_BITS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        we,
  input  logic [ADDR_BITS-1:0]        wr_addr,
  input  logic signed [COEF_BITS-1:0] wr_data,
  input  logic [ADDR_BITS-1:0]        rd_idx,
  output logic signed [COEF_BITS-1:0] rd_data
);

  logic signed [COEF_BITS-1:0] coef_reg [NUM_TAPS];
  logic                        wr_ok;

  assign wr_ok   = we && (int'(wr_addr) < NUM_TAPS);
  assign rd_data = coef_reg[rd_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_TAPS; i++) coef_reg[i] <= '0;
    end else if (wr_ok) begin
      coef_reg[wr_addr] <= wr_data;
    end
  end

endmodule

// File: rtl/fir_mac_serial.sv
// Serial FIR: snapshots the tap vector on start, one signed MAC per clock, then
// emits a scaled result. FIR_MAC_SATURATE_EN selects clamping instead of wrap.
module fir_mac_serial import fir_pkg::*; #(
  parameter int BITS_PER_ELEM = 8,
  parameter int NUM_TAPS      = 9,
  parameter int COEF_BITS     = 8,
  parameter int OUT_BITS      = 8,
  parameter int OUT_SHIFT     = 0
) (
  input logic            clk,
  input logic            rst,
  fir_mac_serial_if.slave bus
);

  localparam int ACC_BITS  = fir_acc_bits(BITS_PER_ELEM, COEF_BITS, NUM_TAPS);
  localparam int PROD_BITS = BITS_PER_ELEM + COEF_BITS;
  localparam int ADDR_BITS = fir_addr_bits(NUM_TAPS);
  localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(NUM_TAPS - 1);

  fir_state_t                   state_reg;
  logic signed [BITS_PER_ELEM-1:0] tap_in   [NUM_TAPS];
  logic signed [BITS_PER_ELEM-1:0] snap_reg [NUM_TAPS];
  logic signed [ACC_BITS-1:0]   acc_reg;
  logic [ADDR_BITS-1:0]         idx_reg;
  logic signed [OUT_BITS-1:0]   value_reg;
  logic                         valid_reg;
  logic                         busy_reg;
  logic                         overrun_reg;

  logic signed [COEF_BITS-1:0]  coef_rd;
  logic signed [PROD_BITS-1:0]  prod;
  logic signed [ACC_BITS-1:0]   prod_ext;
  logic signed [OUT_BITS-1:0]   scaled_next;
  logic                         start_ok;
  logic                         coef_we_ok;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_TAPS; gi++) begin : g_tap_unpack
      assign tap_in[gi] = bus.i_taps[gi*BITS_PER_ELEM +: BITS_PER_ELEM];
    end
  endgenerate

  assign start_ok   = bus.i_start_calc && (state_reg != MAC);
  assign coef_we_ok = bus.i_coef_we && (state_reg != MAC);

  fir_coef_bank #(
    .NUM_TAPS (NUM_TAPS),
    .COEF_BITS(COEF_BITS),
    .ADDR_BITS(ADDR_BITS)
  ) u_coef_bank (
    .clk    (clk),
    .rst    (rst),
    .we     (coef_we_ok),
    .wr_addr(bus.i_coef_addr),
    .wr_data(bus.i_coef_data),
    .rd_idx (idx_reg),
    .rd_data(coef_rd)
  );

  assign prod     = snap_reg[idx_reg] * coef_rd;
  assign prod_ext = ACC_BITS'(prod);

  always_comb begin
    scaled_next = OUT_BITS'(acc_reg >>> OUT_SHIFT);
`ifdef FIR_MAC_SATURATE_EN
    unique case (fir_sat_reduce(64'(acc_reg >>> OUT_SHIFT), OUT_BITS))
      SAT_HI:  scaled_next = {1'b0, {(OUT_BITS-1){1'b1}}};
      SAT_LO:  scaled_next = {1'b1, {(OUT_BITS-1){1'b0}}};
      default: ;
    endcase
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_TAPS; i++) snap_reg[i] <= '0;
    end else if (start_ok) begin
      for (int i = 0; i < NUM_TAPS; i++) snap_reg[i] <= tap_in[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      idx_reg     <= '0;
      value_reg   <= '0;
      valid_reg   <= 1'b0;
      busy_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      valid_reg <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (start_ok) begin
            acc_reg   <= '0;
            idx_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= MAC;
          end
        end
        MAC: begin
          acc_reg <= acc_reg + prod_ext;
          if (bus.i_start_calc) overrun_reg <= 1'b1;
          if (idx_reg == LAST_IDX) begin
            busy_reg  <= 1'b0;
            state_reg <= OUT;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        OUT: begin
          value_reg <= scaled_next;
          valid_reg <= 1'b1;
          // A start here overlaps the result cycle for back-to-back throughput.
          if (start_ok) begin
            acc_reg   <= '0;
            idx_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= MAC;
          end else begin
            state_reg <= IDLE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_value   = value_reg;
  assign bus.o_valid   = valid_reg;
  assign bus.o_busy    = busy_reg;
  assign bus.o_overrun = overrun_reg;

endmodule

// File: tb/tb_fir_mac_serial.sv
// Self-checking bench for fir_mac_serial against an arithmetic FIR reference.
module tb_fir_mac_serial;

  localparam int BPE  = 8;
  localparam int NT   = 9;
  localparam int CB   = 8;
  localparam int OB   = 8;
  localparam int OS   = 0;
  localparam int TAPW = NT * BPE;
  localparam int AB   = 4;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  int   coef_m [NT];

  fir_mac_serial_if #(.BITS_PER_ELEM(BPE), .NUM_TAPS(NT), .COEF_BITS(CB), .OUT_BITS(OB)) bus ();

  fir_mac_serial #(
    .BITS_PER_ELEM(BPE), .NUM_TAPS(NT), .COEF_BITS(CB), .OUT_BITS(OB), .OUT_SHIFT(OS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic signed [OB-1:0] model_out(input logic [TAPW-1:0] taps);
    longint sum;
    longint s;
    longint hi;
    longint lo;
    logic signed [BPE-1:0] t;
    logic signed [OB-1:0] r;
    sum = 0;
    for (int k = 0; k < NT; k++) begin
      t = taps[k*BPE +: BPE];
      sum += longint'(t) * longint'(coef_m[k]);
    end
    s  = sum >>> OS;
    hi = (longint'(1) <<< (OB - 1)) - 1;
    lo = -(longint'(1) <<< (OB - 1));
`ifdef FIR_MAC_SATURATE_EN
    if (s > hi) r = hi[OB-1:0];
    else if (s < lo) r = lo[OB-1:0];
    else r = s[OB-1:0];
`else
    r = s[OB-1:0];
`endif
    return r;
  endfunction

  task automatic write_coef(input int addr, input logic signed [CB-1:0] data);
    @(negedge clk);
    bus.i_coef_we   = 1'b1;
    bus.i_coef_addr = AB'(addr);
    bus.i_coef_data = data;
    @(negedge clk);
    bus.i_coef_we = 1'b0;
    if (addr < NT) coef_m[addr] = int'(data);
  endtask

  function automatic logic [TAPW-1:0] pack_taps(input int v [NT]);
    logic [TAPW-1:0] p;
    for (int k = 0; k < NT; k++) p[k*BPE +: BPE] = BPE'(v[k]);
    return p;
  endfunction

  task automatic do_start(input logic [TAPW-1:0] taps);
    @(negedge clk);
    bus.i_taps       = taps;
    bus.i_start_calc = 1'b1;
    @(negedge clk);
    bus.i_start_calc = 1'b0;
  endtask

  // Called at the negedge after the edge that sampled start.
  task automatic wait_result(output int lat, output int busy_n);
    lat    = -1;
    busy_n = bus.o_busy ? 1 : 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (bus.o_busy) busy_n++;
      if (bus.o_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.i_taps = '0; bus.i_start_calc = 1'b0;
    bus.i_coef_we = 1'b0; bus.i_coef_addr = '0; bus.i_coef_data = '0;
    for (int k = 0; k < NT; k++) coef_m[k] = 0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus.o_value, bus.o_valid, bus.o_busy, bus.o_overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: value=%0d valid=%b busy=%b overrun=%b required all 0",
               bus.o_value, bus.o_valid, bus.o_busy, bus.o_overrun);
    end
    rst = 1'b0;
    @(negedge clk);
    $display("test_reset done");
  endtask

  task automatic test_ones;
    int v [NT];
    int lat, busy_n;
    logic [TAPW-1:0] taps;
    for (int k = 0; k < NT; k++) begin
      write_coef(k, 8'sd1);
      v[k] = k + 1;
    end
    taps = pack_taps(v);
    do_start(taps);
    wait_result(lat, busy_n);
    n_checks++;
    if (lat !== 10) begin
      n_fail++; $display("FAIL ones_latency: got %0d required 10", lat);
    end
    n_checks++;
    if (bus.o_value !== 8'sd45) begin
      n_fail++; $display("FAIL ones_value: got %0d required 45", bus.o_value);
    end
    n_checks++;
    if (busy_n !== 9) begin
      n_fail++; $display("FAIL ones_busy_cycles: got %0d required 9", busy_n);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (bus.o_valid !== 1'b0 || bus.o_value !== 8'sd45) begin
      n_fail++; $display("FAIL ones_hold: valid=%b value=%0d required 0/45", bus.o_valid, bus.o_value);
    end
    $display("test_ones: value=%0d latency=%0d busy=%0d", bus.o_value, lat, busy_n);
  endtask

  task automatic test_impulse;
    int v [NT];
    int lat, busy_n;
    for (int k = 0; k < NT; k++) begin
      write_coef(k, CB'(k + 1));
      v[k] = (k == 3) ? 1 : 0;
    end
    do_start(pack_taps(v));
    wait_result(lat, busy_n);
    n_checks++;
    if (lat !== 10 || bus.o_value !== 8'sd4) begin
      n_fail++; $display("FAIL impulse: value=%0d lat=%0d required 4/10", bus.o_value, lat);
    end
    $display("test_impulse: value=%0d", bus.o_value);
  endtask

  task automatic test_extremes;
    int v [NT];
    int lat, busy_n;
    logic signed [OB-1:0] exp_v;
    for (int k = 0; k < NT; k++) begin
      write_coef(k, -8'sd128);
      v[k] = -128;
    end
    do_start(pack_taps(v));
    wait_result(lat, busy_n);
`ifdef FIR_MAC_SATURATE_EN
    exp_v = 8'sd127;
`else
    exp_v = 8'sd0;
`endif
    n_checks++;
    if (lat !== 10 || bus.o_value !== exp_v) begin
      n_fail++; $display("FAIL extreme_pos: value=%0d lat=%0d required %0d/10", bus.o_value, lat, exp_v);
    end
    $display("test_extremes pos: value=%0d", bus.o_value);
    for (int k = 0; k < NT; k++) write_coef(k, 8'sd127);
    do_start(pack_taps(v));
    wait_result(lat, busy_n);
    n_checks++;
    if (lat !== 10 || bus.o_value !== -8'sd128) begin
      n_fail++; $display("FAIL extreme_neg: value=%0d lat=%0d required -128/10", bus.o_value, lat);
    end
    $display("test_extremes neg: value=%0d", bus.o_value);
  endtask

  task automatic test_random;
    logic [TAPW-1:0] taps;
    logic signed [OB-1:0] exp_v;
    int lat, busy_n;
    for (int k = 0; k < NT; k++) write_coef(k, CB'($urandom));
    for (int it = 0; it < 16; it++) begin
      if (it == 8) write_coef(int'($urandom_range(0, NT - 1)), CB'($urandom));
      for (int k = 0; k < NT; k++) taps[k*BPE +: BPE] = BPE'($urandom);
      exp_v = model_out(taps);
      do_start(taps);
      wait_result(lat, busy_n);
      n_checks++;
      if (lat !== 10 || bus.o_value !== exp_v) begin
        n_fail++;
        $display("FAIL random_%0d: value=%0d lat=%0d required %0d/10", it, bus.o_value, lat, exp_v);
      end
      $display("test_random %0d: value=%0d expected=%0d", it, bus.o_value, exp_v);
    end
  endtask

  task automatic test_coef_guard;
    logic [TAPW-1:0] taps;
    logic signed [OB-1:0] exp_v;
    int lat, busy_n;
    for (int k = 0; k < NT; k++) begin
      write_coef(k, CB'(k - 4));
      taps[k*BPE +: BPE] = BPE'(3 * k + 7);
    end
    exp_v = model_out(taps);
    do_start(taps);
    @(negedge clk);
    bus.i_coef_we = 1'b1; bus.i_coef_addr = '0; bus.i_coef_data = 8'sd5;
    @(negedge clk);
    bus.i_coef_we = 1'b0;
    wait_result(lat, busy_n);
    n_checks++;
    if (bus.o_value !== exp_v) begin
      n_fail++; $display("FAIL busy_write_inflight: value=%0d required %0d", bus.o_value, exp_v);
    end
    write_coef(12, 8'sd77);
    do_start(taps);
    wait_result(lat, busy_n);
    n_checks++;
    if (lat !== 10 || bus.o_value !== exp_v) begin
      n_fail++; $display("FAIL busy_write_readback: value=%0d lat=%0d required %0d/10", bus.o_value, lat, exp_v);
    end
    $display("test_coef_guard: value=%0d expected=%0d", bus.o_value, exp_v);
  endtask

  task automatic test_back_to_back;
    logic [TAPW-1:0] ta, tb;
    logic signed [OB-1:0] ea, eb;
    int lat, busy_n;
    for (int k = 0; k < NT; k++) begin
      ta[k*BPE +: BPE] = BPE'($urandom);
      tb[k*BPE +: BPE] = BPE'($urandom);
    end
    ea = model_out(ta);
    eb = model_out(tb);
    do_start(ta);
    repeat (8) @(negedge clk);
    do_start(tb);
    n_checks++;
    if (bus.o_valid !== 1'b1 || bus.o_value !== ea || bus.o_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: valid=%b busy=%b value=%0d required 1/1/%0d",
               bus.o_valid, bus.o_busy, bus.o_value, ea);
    end
    wait_result(lat, busy_n);
    n_checks++;
    if (lat !== 10 || bus.o_value !== eb) begin
      n_fail++; $display("FAIL b2b_second: value=%0d lat=%0d required %0d/10", bus.o_value, lat, eb);
    end
    $display("test_back_to_back: first=%0d second=%0d spacing=%0d", ea, bus.o_value, lat);
  endtask

  task automatic test_overrun;
    logic [TAPW-1:0] ta, tb;
    logic signed [OB-1:0] ea;
    int n_valid, first_c;
    for (int k = 0; k < NT; k++) begin
      ta[k*BPE +: BPE] = BPE'($urandom);
      tb[k*BPE +: BPE] = BPE'($urandom);
    end
    ea = model_out(ta);
    do_start(ta);
    @(negedge clk);
    @(negedge clk);
    bus.i_taps = tb; bus.i_start_calc = 1'b1;
    @(negedge clk);
    bus.i_start_calc = 1'b0;
    n_valid = 0; first_c = -1;
    for (int c = 4; c <= 30; c++) begin
      if (bus.o_valid) begin
        n_valid++;
        if (first_c < 0) begin
          first_c = c - 1;
          n_checks++;
          if (bus.o_value !== ea) begin
            n_fail++; $display("FAIL overrun_value: got %0d required %0d", bus.o_value, ea);
          end
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (n_valid !== 1 || first_c !== 10) begin
      n_fail++; $display("FAIL overrun_pulses: count=%0d at=%0d required 1 at 10", n_valid, first_c);
    end
    n_checks++;
    if (bus.o_overrun !== 1'b1) begin
      n_fail++; $display("FAIL overrun_sticky: got %b required 1", bus.o_overrun);
    end
    $display("test_overrun: value=%0d pulses=%0d overrun=%b", bus.o_value, n_valid, bus.o_overrun);
  endtask

  task automatic test_reset_mid_mac;
    logic [TAPW-1:0] taps;
    int n_valid, lat, busy_n;
    for (int k = 0; k < NT; k++) taps[k*BPE +: BPE] = BPE'(k + 20);
    do_start(taps);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if ({bus.o_value, bus.o_valid, bus.o_busy, bus.o_overrun} !== '0) begin
      n_fail++;
      $display("FAIL midmac_reset_outputs: value=%0d valid=%b busy=%b overrun=%b required all 0",
               bus.o_value, bus.o_valid, bus.o_busy, bus.o_overrun);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < NT; k++) coef_m[k] = 0;
    n_valid = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.o_valid) n_valid++;
    end
    n_checks++;
    if (n_valid !== 0 || bus.o_busy !== 1'b0) begin
      n_fail++; $display("FAIL midmac_no_valid: pulses=%0d busy=%b required 0/0", n_valid, bus.o_busy);
    end
    do_start(taps);
    wait_result(lat, busy_n);
    n_checks++;
    if (lat !== 10 || bus.o_value !== 8'sd0 || bus.o_overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_coefs: value=%0d lat=%0d overrun=%b required 0/10/0",
               bus.o_value, lat, bus.o_overrun);
    end
    $display("test_reset_mid_mac: post-reset value=%0d", bus.o_value);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_ones();
    test_impulse();
    test_extremes();
    test_random();
    test_coef_guard();
    test_back_to_back();
    test_overrun();
    test_reset_mid_mac();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
